// File: rtl/dtcore32_pkg.sv
// Shared types and constants for the dtcore32 writeback path.
package dtcore32_pkg;

   typedef enum logic [1:0] {
      RES_ALU  = 2'b00,
      RES_LOAD = 2'b01,
      RES_PC4  = 2'b10,
      RES_CSR  = 2'b11
   } result_src_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      WB_EMPTY    = 2'b00,
      WB_COMMIT   = 2'b01,
      WB_WAIT_RSP = 2'b10
   } wb_state_e;

endpackage

// File: rtl/dtcore32_load_align.sv
// Picks the addressed byte/halfword out of a raw load word and extends it.
module dtcore32_load_align
   import dtcore32_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] raw,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = raw[7:0];
      case (offset)
         2'd1:    byte_sel = raw[15:8];
         2'd2:    byte_sel = raw[23:16];
         2'd3:    byte_sel = raw[31:24];
         default: byte_sel = raw[7:0];
      endcase
      half_sel = offset[1] ? raw[31:16] : raw[15:0];
   end

   // Reserved funct3 encodings return zero rather than garbage.
   always_comb begin
      data = '0;
      case (funct3)
         F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU:  data = {24'b0, byte_sel};
         F3_LH:   data = {{16{half_sel[15]}}, half_sel};
         F3_LHU:  data = {16'b0, half_sel};
         F3_LW:   data = raw;
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/dtcore32_wb_stage.sv
// Writeback stage: MEM/WB register, load response wait, regfile write port, instret.
module dtcore32_wb_stage
   import dtcore32_pkg::*;
#(
   parameter int INSTRET_W = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 mem_valid_i,
   output logic                 mem_ready_o,
   input  logic [4:0]           mem_rd_addr_i,
   input  logic [1:0]           mem_result_src_i,
   input  logic [2:0]           mem_funct3_i,
   input  logic [31:0]          mem_alu_result_i,
   input  logic [31:0]          mem_pc_plus4_i,
   input  logic [31:0]          mem_csr_rdata_i,
   input  logic                 dmem_rvalid_i,
   input  logic [31:0]          dmem_rdata_i,
   output logic [4:0]           rd_addr_o,
   output logic [31:0]          reg_wr_data_o,
   output logic                 retire_o,
   output logic [INSTRET_W-1:0] instret_o,
   output logic                 wb_busy_o
);

   wb_state_e   state;
   result_src_e src;
   logic [4:0]  ld_rd_q;
   logic [2:0]  ld_f3_q;
   logic [1:0]  ld_off_q;
   logic [31:0] ld_data;
   logic [31:0] res_sel;
   logic        accept;

   assign src         = result_src_e'(mem_result_src_i);
   assign mem_ready_o = (state != WB_WAIT_RSP);
   assign wb_busy_o   = (state == WB_WAIT_RSP);
   assign accept      = mem_valid_i && mem_ready_o;

   always_comb begin
      res_sel = mem_alu_result_i;
      case (src)
         RES_PC4: res_sel = mem_pc_plus4_i;
         RES_CSR: res_sel = mem_csr_rdata_i;
         default: res_sel = mem_alu_result_i;
      endcase
   end

   dtcore32_load_align u_align (
      .funct3 (ld_f3_q),
      .offset (ld_off_q),
      .raw    (dmem_rdata_i),
      .data   (ld_data)
   );

   // Write-port outputs are loaded on the edge that enters COMMIT, so they are
   // stable for the whole commit cycle and zero in every other cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state         <= WB_EMPTY;
         ld_rd_q       <= '0;
         ld_f3_q       <= '0;
         ld_off_q      <= '0;
         rd_addr_o     <= '0;
         reg_wr_data_o <= '0;
         retire_o      <= 1'b0;
         instret_o     <= '0;
      end else begin
         rd_addr_o     <= '0;
         reg_wr_data_o <= '0;
         retire_o      <= 1'b0;
         if (state == WB_COMMIT)
            instret_o <= instret_o + INSTRET_W'(1);
         if (accept) begin
            if (src == RES_LOAD) begin
               state    <= WB_WAIT_RSP;
               ld_rd_q  <= mem_rd_addr_i;
               ld_f3_q  <= mem_funct3_i;
               ld_off_q <= mem_alu_result_i[1:0];
            end else begin
               state         <= WB_COMMIT;
               rd_addr_o     <= mem_rd_addr_i;
               reg_wr_data_o <= res_sel;
               retire_o      <= 1'b1;
            end
         end else if (state == WB_WAIT_RSP && dmem_rvalid_i) begin
            state         <= WB_COMMIT;
            rd_addr_o     <= ld_rd_q;
            reg_wr_data_o <= ld_data;
            retire_o      <= 1'b1;
         end else if (state == WB_COMMIT) begin
            state <= WB_EMPTY;
         end
      end
   end

endmodule

// File: tb/tb_dtcore32_wb_stage.sv
// Directed bench for dtcore32_wb_stage with a per-cycle reference model.
module tb_dtcore32_wb_stage;
   localparam int IW = 8;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          mem_valid_i = 1'b0;
   logic          mem_ready_o;
   logic [4:0]    mem_rd_addr_i = '0;
   logic [1:0]    mem_result_src_i = '0;
   logic [2:0]    mem_funct3_i = '0;
   logic [31:0]   mem_alu_result_i = '0;
   logic [31:0]   mem_pc_plus4_i = '0;
   logic [31:0]   mem_csr_rdata_i = '0;
   logic          dmem_rvalid_i = 1'b0;
   logic [31:0]   dmem_rdata_i = '0;
   logic [4:0]    rd_addr_o;
   logic [31:0]   reg_wr_data_o;
   logic          retire_o;
   logic [IW-1:0] instret_o;
   logic          wb_busy_o;

   int n_cmp = 0;
   int n_fail = 0;

   dtcore32_wb_stage #(.INSTRET_W(IW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o),
      .mem_rd_addr_i(mem_rd_addr_i), .mem_result_src_i(mem_result_src_i),
      .mem_funct3_i(mem_funct3_i), .mem_alu_result_i(mem_alu_result_i),
      .mem_pc_plus4_i(mem_pc_plus4_i), .mem_csr_rdata_i(mem_csr_rdata_i),
      .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
      .rd_addr_o(rd_addr_o), .reg_wr_data_o(reg_wr_data_o),
      .retire_o(retire_o), .instret_o(instret_o), .wb_busy_o(wb_busy_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference: value of a load computed by shifting the word down to the
   // addressed lane and extending.
   function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] w);
      logic [31:0] b, h;
      b = (w >> (8 * off)) & 32'hFF;
      h = (w >> (16 * off[1])) & 32'hFFFF;
      case (f3)
         3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
         3'b100:  return b;
         3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
         3'b101:  return h;
         3'b010:  return w;
         default: return 32'h0;
      endcase
   endfunction

   // Model: one pending load (if any) and the instruction committing this cycle.
   logic          m_wait = 0, m_commit = 0;
   logic [4:0]    m_rd = 0, l_rd = 0;
   logic [31:0]   m_data = 0;
   logic [2:0]    l_f3 = 0;
   logic [1:0]    l_off = 0;
   logic [IW-1:0] m_cnt = 0;

   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         m_wait <= 0; m_commit <= 0; m_rd <= 0; m_data <= 0; m_cnt <= 0;
         l_rd <= 0; l_f3 <= 0; l_off <= 0;
      end else begin
         if (m_commit) m_cnt <= m_cnt + 1'b1;
         m_commit <= 0;
         if (mem_valid_i && !m_wait) begin
            if (mem_result_src_i == 2'b01) begin
               m_wait <= 1; l_rd <= mem_rd_addr_i; l_f3 <= mem_funct3_i;
               l_off <= mem_alu_result_i[1:0];
            end else begin
               m_commit <= 1; m_rd <= mem_rd_addr_i;
               m_data <= (mem_result_src_i == 2'b10) ? mem_pc_plus4_i :
                         (mem_result_src_i == 2'b11) ? mem_csr_rdata_i : mem_alu_result_i;
            end
         end else if (m_wait && dmem_rvalid_i) begin
            m_wait <= 0; m_commit <= 1; m_rd <= l_rd;
            m_data <= load_value(l_f3, l_off, dmem_rdata_i);
         end
      end
   end

   always @(negedge clk_i) begin
      logic [4:0]  e_rd;
      logic [31:0] e_data;
      e_rd   = m_commit ? m_rd : 5'd0;
      e_data = m_commit ? m_data : 32'd0;
      n_cmp++;
      if (rd_addr_o !== e_rd || reg_wr_data_o !== e_data || retire_o !== m_commit ||
          instret_o !== m_cnt || wb_busy_o !== m_wait || mem_ready_o !== !m_wait) begin
         n_fail++;
         $display("FAIL model t=%0t got rd=%0d d=%h ret=%b cnt=%0d busy=%b rdy=%b want rd=%0d d=%h ret=%b cnt=%0d busy=%b rdy=%b",
                  $time, rd_addr_o, reg_wr_data_o, retire_o, instret_o, wb_busy_o, mem_ready_o,
                  e_rd, e_data, m_commit, m_cnt, m_wait, !m_wait);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic op(input logic v, input logic [4:0] rd, input logic [1:0] src,
                     input logic [2:0] f3, input logic [31:0] alu, input logic rv,
                     input logic [31:0] rdata);
      mem_valid_i = v; mem_rd_addr_i = rd; mem_result_src_i = src; mem_funct3_i = f3;
      mem_alu_result_i = alu; dmem_rvalid_i = rv; dmem_rdata_i = rdata;
      @(negedge clk_i);
   endtask

   task automatic idle();
      op(0, 0, 0, 0, 0, 0, 0);
   endtask

   // Accept a load, wait gap idle cycles, then return the response.
   task automatic ld_test(input string name, input logic [2:0] f3, input logic [1:0] off,
                          input logic [31:0] rdata, input int gap, input logic [31:0] exp);
      op(1, 5'd9, 2'b01, f3, {30'h100, off}, 0, 0);
      chk({name, "_busy"}, {31'b0, wb_busy_o}, 1);
      for (int i = 0; i < gap; i++) begin
         idle();
         chk({name, "_rdy"}, {31'b0, mem_ready_o}, 0);
      end
      op(0, 0, 0, 0, 0, 1, rdata);
      chk({name, "_data"}, reg_wr_data_o, exp);
      chk({name, "_rd"}, {27'b0, rd_addr_o}, 9);
      idle();
   endtask

   initial begin
      repeat (2) @(negedge clk_i);
      chk("rst_rd", {27'b0, rd_addr_o}, 0);
      chk("rst_data", reg_wr_data_o, 0);
      chk("rst_retire", {31'b0, retire_o}, 0);
      chk("rst_busy", {31'b0, wb_busy_o}, 0);
      chk("rst_ready", {31'b0, mem_ready_o}, 1);
      rst_ni = 1'b1;
      @(negedge clk_i);

      op(1, 5'd5, 2'b00, 0, 32'h1234_5678, 0, 0);
      chk("alu_rd", {27'b0, rd_addr_o}, 5);
      chk("alu_data", reg_wr_data_o, 32'h1234_5678);
      chk("alu_retire", {31'b0, retire_o}, 1);
      chk("alu_cnt0", {24'b0, instret_o}, 0);
      idle();
      chk("alu_cnt1", {24'b0, instret_o}, 1);
      chk("alu_rd_idle", {27'b0, rd_addr_o}, 0);

      for (int i = 1; i <= 3; i++) begin
         mem_pc_plus4_i = 32'h0;
         op(1, 5'(i), 2'b00, 0, 32'hA000_0000 + 32'(i), 0, 0);
         chk("b2b_retire", {31'b0, retire_o}, 1);
         chk("b2b_ready", {31'b0, mem_ready_o}, 1);
         chk("b2b_rd", {27'b0, rd_addr_o}, 32'(i));
      end
      idle();
      chk("b2b_cnt", {24'b0, instret_o}, 4);

      ld_test("lb", 3'b000, 2'd3, 32'h80FF_0000, 1, 32'hFFFF_FF80);
      ld_test("lbu", 3'b100, 2'd3, 32'h80FF_0000, 1, 32'h0000_0080);
      ld_test("lh", 3'b001, 2'd2, 32'h9ABC_0000, 1, 32'hFFFF_9ABC);
      ld_test("lhu", 3'b101, 2'd2, 32'h9ABC_0000, 0, 32'h0000_9ABC);
      ld_test("lw", 3'b010, 2'd1, 32'h9ABC_0000, 0, 32'h9ABC_0000);
      ld_test("lb1", 3'b000, 2'd1, 32'h1234_7F56, 2, 32'h0000_007F);
      ld_test("f3_011", 3'b011, 2'd0, 32'hDEAD_BEEF, 0, 32'h0);

      mem_pc_plus4_i = 32'h100;
      op(1, 5'd0, 2'b10, 0, 32'h55, 0, 0);
      chk("x0_rd", {27'b0, rd_addr_o}, 0);
      chk("x0_retire", {31'b0, retire_o}, 1);
      op(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
      chk("stray_commit", {31'b0, retire_o}, 0);
      op(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
      chk("stray_empty", {31'b0, retire_o}, 0);

      mem_csr_rdata_i = 32'hC5C5_0001;
      op(1, 5'd31, 2'b11, 0, 0, 0, 0);
      chk("csr_data", reg_wr_data_o, 32'hC5C5_0001);

      // Enough back-to-back commits to wrap the narrow counter.
      for (int i = 0; i < 260; i++)
         op(1, 5'(i), 2'b00, 0, 32'(i) * 32'h0101_0101, 0, 0);
      idle();

      op(1, 5'd12, 2'b01, 3'b010, 32'h200, 0, 0);
      #2 rst_ni = 1'b0;
      #1 chk("rst_mid_busy", {31'b0, wb_busy_o}, 0);
      chk("rst_mid_cnt", {24'b0, instret_o}, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      op(0, 0, 0, 0, 0, 1, 32'h1111_2222);
      chk("rst_stray_ret", {31'b0, retire_o}, 0);
      chk("rst_stray_rd", {27'b0, rd_addr_o}, 0);
      idle();
      chk("rst_cnt", {24'b0, instret_o}, 0);
      chk("rst_data_after", reg_wr_data_o, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
